md_issue_ctrl: RTL

- Pipeline-side initiator for the multiply/divide unit.
- Takes mult/div/mfhi/mflo/mthi/mtlo requests from the E stage and drives the unit's start, MDop, HIwrite, LOwrite and operand inputs.
- Tracks the unit's busy window with its own FSM and stalls the D stage while an MD-class instruction must wait.
- Returns HI/LO read data to E for mfhi/mflo and flags a latency watchdog error.

---
 rtl/md_issue_ctrl_pkg.sv | 32 +++
 rtl/md_issue_ctrl_watchdog.sv | 38 +++
 rtl/md_issue_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the multiply/divide issue controller: MDop codes,
// E-stage MD instruction encodings and the issue FSM state type.
package md_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULTU = 3'd0,
    MD_MULT  = 3'd1,
    MD_DIVU  = 3'd2,
    MD_DIV   = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_type_e;

  localparam logic [2:0] MDOP_MULTU = 3'b000;
  localparam logic [2:0] MDOP_MULT  = 3'b001;
  localparam logic [2:0] MDOP_DIVU  = 3'b010;
  localparam logic [2:0] MDOP_DIV   = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } md_state_e;

  // Types 0..3 start a multi-cycle operation; 4..7 only touch HI/LO.
  function automatic logic is_arith(input logic [2:0] md_type);
    return ~md_type[2];
  endfunction

endpackage

// File: rtl/md_issue_ctrl_watchdog.sv
// Latency watchdog for the MD busy window: counts BUSY cycles with md_busy
// high, flags expiry at MAX_LAT and keeps a sticky error until reset.
module md_issue_ctrl_watchdog #(
  parameter int MAX_LAT = 16,
  parameter int CW      = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic md_busy,
  output logic expire,
  output logic md_err
);

  localparam logic [CW-1:0] LAST = CW'(MAX_LAT - 1);

  logic [CW-1:0] count;

  // Expiry fires on the MAX_LAT-th busy cycle, so the FSM leaves BUSY on that edge.
  assign expire = active & md_busy & (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      md_err <= 1'b0;
    end else begin
      if (!active || !md_busy || expire) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
      if (expire) begin
        md_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Pipeline-side initiator for the multiply/divide unit: issues start pulses
// and HI/LO writes from E, tracks the busy window and stalls D behind it.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MAX_LAT = 16,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_md_req,
  input  logic [2:0]  e_md_type,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_md,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_hiwrite,
  output logic        md_lowrite,
  output logic        stall_d,
  output logic [31:0] e_md_rdata,
  output logic        md_err
);

  md_state_e state;
  md_state_e state_next;
  logic      accept;
  logic      idle;
  logic      expire;

  md_issue_ctrl_watchdog #(
    .MAX_LAT (MAX_LAT),
    .CW      (CW)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .active  (state == ST_BUSY),
    .md_busy (md_busy),
    .expire  (expire),
    .md_err  (md_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Requests seen outside IDLE are dropped silently; stall_d keeps them from happening.
  always_comb begin
    idle       = (state == ST_IDLE);
    accept     = ~reset & e_md_req & is_arith(e_md_type) & idle;
    state_next = state;
    md_start   = 1'b0;
    md_op      = MDOP_MULTU;
    md_hiwrite = 1'b0;
    md_lowrite = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ISSUE;
          md_start   = 1'b1;
          md_op      = e_md_type;
        end
        if (!reset && e_md_req) begin
          md_hiwrite = (e_md_type == MD_MTHI);
          md_lowrite = (e_md_type == MD_MTLO);
        end
      end
      ST_ISSUE: begin
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (!md_busy || expire) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The accept term holds a back-to-back MD instruction until HI/LO are final.
  always_comb begin
    stall_d = d_is_md & (~idle | accept);
    md_a    = e_rs;
    md_b    = e_rt;
    case (e_md_type)
      MD_MFHI: e_md_rdata = md_hi;
      MD_MFLO: e_md_rdata = md_lo;
      default: e_md_rdata = 32'd0;
    endcase
  end

endmodule
